// File: rtl/sram_rr_arbiter.sv
// Two-port round-robin front end for a single-port 2048x32 SRAM macro.
// Zero-fills the array after reset, then arbitrates p0/p1 requests with per-port read buffers.
module sram_rr_arbiter #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4,
  parameter int INIT_ZERO   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_done,

  input  logic                   p0_req_valid,
  output logic                   p0_req_ready,
  input  logic                   p0_req_we,
  input  logic [WMASK_WIDTH-1:0] p0_req_wmask,
  input  logic [ADDR_WIDTH-1:0]  p0_req_addr,
  input  logic [DATA_WIDTH-1:0]  p0_req_wdata,
  output logic                   p0_rsp_valid,
  input  logic                   p0_rsp_ready,
  output logic [DATA_WIDTH-1:0]  p0_rsp_rdata,

  input  logic                   p1_req_valid,
  output logic                   p1_req_ready,
  input  logic                   p1_req_we,
  input  logic [WMASK_WIDTH-1:0] p1_req_wmask,
  input  logic [ADDR_WIDTH-1:0]  p1_req_addr,
  input  logic [DATA_WIDTH-1:0]  p1_req_wdata,
  output logic                   p1_rsp_valid,
  input  logic                   p1_rsp_ready,
  output logic [DATA_WIDTH-1:0]  p1_rsp_rdata,

  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] icnt;
  logic                  rr;
  logic                  pend0, pend1;
  logic                  run;
  logic                  read_ok0, read_ok1;
  logic                  elig0, elig1;
  logic                  grant0, grant1;

  // Everything is gated by rst_n so the macro and clients see silence while reset is held.
  assign run       = rst_n && (state == RUN);
  assign init_done = run;

  // A read may only issue when its response slot is free or being emptied this cycle.
  assign read_ok0 = !pend0 && (!p0_rsp_valid || p0_rsp_ready);
  assign read_ok1 = !pend1 && (!p1_rsp_valid || p1_rsp_ready);
  assign elig0    = run && p0_req_valid && (p0_req_we || read_ok0);
  assign elig1    = run && p1_req_valid && (p1_req_we || read_ok1);
  assign grant0   = elig0 && (!elig1 || !rr);
  assign grant1   = elig1 && (!elig0 || rr);

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;

  always_comb begin
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (rst_n && state == INIT) begin
      sram_we    = 1'b1;
      sram_wmask = '1;
      sram_addr  = icnt;
    end else if (grant0) begin
      sram_we    = p0_req_we;
      sram_wmask = p0_req_wmask;
      sram_addr  = p0_req_addr;
      sram_din   = p0_req_wdata;
    end else if (grant1) begin
      sram_we    = p1_req_we;
      sram_wmask = p1_req_wmask;
      sram_addr  = p1_req_addr;
      sram_din   = p1_req_wdata;
    end
  end

  // The macro's registered read means dout is valid the cycle after a read grant,
  // which is exactly when pend is high; a capture wins over a simultaneous pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= (INIT_ZERO != 0) ? INIT : RUN;
      icnt         <= '0;
      rr           <= 1'b0;
      pend0        <= 1'b0;
      pend1        <= 1'b0;
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_rdata <= '0;
    end else begin
      case (state)
        INIT: begin
          icnt <= icnt + 1'b1;
          if (icnt == {ADDR_WIDTH{1'b1}}) begin
            state <= RUN;
            icnt  <= '0;
          end
        end
        RUN: begin
          if (grant0) begin
            rr <= 1'b1;
          end else if (grant1) begin
            rr <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase

      pend0 <= grant0 && !p0_req_we;
      pend1 <= grant1 && !p1_req_we;

      if (pend0) begin
        p0_rsp_rdata <= sram_dout;
        p0_rsp_valid <= 1'b1;
      end else if (p0_rsp_valid && p0_rsp_ready) begin
        p0_rsp_valid <= 1'b0;
      end

      if (pend1) begin
        p1_rsp_rdata <= sram_dout;
        p1_rsp_valid <= 1'b1;
      end else if (p1_rsp_valid && p1_rsp_ready) begin
        p1_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sram_rr_arbiter.md
# sram_rr_arbiter

Two-requester controller in front of one single-port SRAM22 macro (2048x32, byte write mask, 1-cycle registered read). Zero-fills the array after reset, then shares the macro between ports p0 and p1 with round-robin arbitration, valid/ready request handshakes and a one-entry backpressured read-response buffer per port. It sits between the macro and the two bus clients.

## Interface
- ADDR_WIDTH, 11, SRAM word address width
- DATA_WIDTH, 32, data width
- WMASK_WIDTH, 4, byte-lane write mask width (DATA_WIDTH/8)
- INIT_ZERO, 1, 1: zero-fill all 2^ADDR_WIDTH words after reset; 0: skip
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- init_done  out  1  high once zero-fill is complete
- pN_req_valid  in  1  request valid (N = 0, 1)
- pN_req_ready  out  1  request accepted this cycle when valid & ready
- pN_req_we  in  1  1 write, 0 read
- pN_req_wmask  in  WMASK_WIDTH  byte enables, writes only
- pN_req_addr  in  ADDR_WIDTH  word address
- pN_req_wdata  in  DATA_WIDTH  write data
- pN_rsp_valid  out  1  read data valid
- pN_rsp_ready  in  1  consumer accepts read data
- pN_rsp_rdata  out  DATA_WIDTH  read data
- sram_we  out  1  to macro we
- sram_wmask  out  WMASK_WIDTH  to macro wmask
- sram_addr  out  ADDR_WIDTH  to macro addr
- sram_din  out  DATA_WIDTH  to macro din
- sram_dout  in  DATA_WIDTH  from macro dout

## Operation
- States: INIT, RUN. The cycle with rst_n low loads INIT if INIT_ZERO=1, else RUN.
- INIT: counter icnt from 0; each cycle drive sram_we=1, sram_wmask all ones, sram_din=0, sram_addr=icnt; icnt++. After icnt = 2^ADDR_WIDTH-1 is written, go to RUN. Both req_ready held 0.
- RUN: init_done=1. Port N is eligible when req_valid & (req_we | read_ok_N), where read_ok_N = !pend_N & (!rsp_valid_N | rsp_ready_N).
- Writes are always eligible and produce no response.
- Round-robin pointer rr (reset 0) names the favoured port. One eligible port: grant it. Both eligible: grant port rr. After any grant, rr = other port. No grant: rr unchanged.
- req_ready_N = grant_N (combinational). An ineligible valid request waits; a requester may change its request while not granted.
- Granted request drives sram_we/wmask/addr/din from that port's fields, same cycle.
- No grant in RUN: sram_we=0, sram_addr=0, sram_wmask=0, sram_din=0. The macro performs an idle read; its result is ignored.
- Read grant sets pend_N. Next cycle: rsp_rdata_N <= sram_dout, rsp_valid_N <= 1, pend_N <= 0.
- rsp_valid_N clears on rsp_valid_N & rsp_ready_N unless a capture occurs the same cycle. In that case it stays 1 with the new data.
- Response order per port equals request order; at most one read outstanding per port.
- Reset (any state, any cycle): rr=0, pend=0, rsp_valid=0, rsp_rdata=0, icnt=0, init_done=0. In-flight reads are dropped and zero-fill restarts.

## Timing
- While rst_n low: req_ready=0, sram_we=0, rsp_valid=0, init_done=0.
- INIT_ZERO=1: zero-fill takes cycles 0..2047 after reset release. init_done is 1 and the first grant is possible in cycle 2048. INIT_ZERO=0: both occur in cycle 0.
- Read latency: handshake in cycle t, rsp_valid high from cycle t+2, data stable until popped.
- Write is committed at the edge ending the handshake cycle. A read of the same address granted in the following cycle returns the new data.
- Throughput: one access per cycle total. A single port reading back-to-back achieves one read per 2 cycles. The two ports alternating achieve one read per cycle.
- Critical path: eligibility -> grant -> req_ready and sram_* outputs, combinational within one cycle.

## Test plan
- Reset release, INIT_ZERO=1: sram_we=1 with addresses 0..2047 over 2048 cycles; init_done rises in cycle 2048. Read addr 0x7FF -> rdata 0x00000000.
- p0 write addr 0x010, data 0xDEADBEEF, wmask 4'b1111. Then write 0x11223344 with wmask 4'b0101. Then read -> 0xDE22BE44, rsp_valid exactly 2 cycles after the read handshake.
- Both ports hold valid reads for 6 cycles, rsp_ready=1: grants alternate p0, p1, p0, ... starting at p0 after reset. Each port gets its own data, in order.
- p1 rsp_ready=0 with rsp_valid=1: p1 reads are not granted while p1 writes and p0 reads proceed. Raising rsp_ready pops the data and grants the next read in the same cycle.
- Pop and capture in the same cycle, from a read granted while rsp_valid=1 and rsp_ready=1: rsp_valid stays 1 with the new rdata. No data is lost or duplicated.
- Assert rst_n=0 for 1 cycle at icnt=1000 and again with a p0 read pending: pend and rsp_valid clear, zero-fill restarts at addr 0, and no response is emitted for the dropped read.
